rgb_wpack: RTL and testbench

Upstream neighbour of the RGBW serial-output stage. Consumes decoded-bit events (strobe, stream_reset, sbit_value) from the WS2812b input bit decoder, assembles 24-bit G-R-B pixel words MSB-first and writes them, plus stream-reset marker words, into the 32-bit FIFO that the RGBW output stage drains. A one-entry holding register absorbs FIFO backpressure; overflow is flagged, never stalls the input.

---
 rtl/rgb_wpack.sv | 141 ++++++++++++++
 tb/tb_rgb_wpack.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_wpack.sv
// Packs WS2812b decoded-bit events into 32-bit G-R-B / stream-reset words for the RGBW output FIFO.
// Optional per-pixel index in [29:24] is enabled by defining RGB_WPACK_PIX_IDX_EN.
module rgb_wpack #(
  parameter bit SRST_ALWAYS = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_strobe,
  input  logic        in_stream_reset,
  input  logic        in_sbit_value,
  input  logic        in_wr_fifo_full,
  output logic        out_wr_fifo_en,
  output logic [31:0] out_wr_fifo_data,
  output logic        out_overflow,
  output logic        out_frag_err
);

  typedef struct packed {
    logic        vld;
    logic        srst;
    logic [5:0]  idx;
    logic [23:0] pix;
  } word_t;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic        strobe_d;
  logic        ev, ev_bit, ev_srst;
  logic [0:0]  state;
  logic [4:0]  cnt;
  logic [22:0] shift;
  logic        seen_word;
  logic        word_done;
  logic [5:0]  idx;

  logic        pending;
  word_t       hold;
  logic        rel;
  logic        enq;
  word_t       enq_word;

  // Strobe lasts several clocks; only its rising edge is an event.
  always_comb begin
    ev        = in_strobe & ~strobe_d;
    ev_bit    = ev & ~in_stream_reset;
    ev_srst   = ev & in_stream_reset;
    word_done = ev_bit && (state == ST_COLLECT) && (cnt == 5'd23);
    rel       = pending & ~in_wr_fifo_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe_d <= 1'b0;
    else      strobe_d <= in_strobe;
  end

`ifdef RGB_WPACK_PIX_IDX_EN
  logic [5:0] pix_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           pix_idx <= '0;
    else if (ev_srst)   pix_idx <= '0;
    else if (word_done) pix_idx <= pix_idx + 6'd1;
  end

  assign idx = pix_idx;
`else
  assign idx = '0;
`endif

  always_comb begin
    enq      = 1'b0;
    enq_word = '0;
    if (word_done) begin
      enq          = 1'b1;
      enq_word.vld = 1'b1;
      enq_word.idx = idx;
      enq_word.pix = {shift, in_sbit_value};
    end else if (ev_srst && (seen_word || SRST_ALWAYS)) begin
      enq           = 1'b1;
      enq_word.vld  = 1'b1;
      enq_word.srst = 1'b1;
    end
  end

  // Bit collector: shift holds at most 23 pending bits; the 24th goes straight into the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shift        <= '0;
      seen_word    <= 1'b0;
      out_frag_err <= 1'b0;
    end else if (ev_srst) begin
      if (cnt != 5'd0) out_frag_err <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= '0;
      shift     <= '0;
      seen_word <= 1'b0;
    end else if (ev_bit) begin
      shift <= {shift[21:0], in_sbit_value};
      case (state)
        ST_IDLE: begin
          cnt   <= 5'd1;
          state <= ST_COLLECT;
        end
        default: begin
          if (cnt == 5'd23) begin
            cnt       <= '0;
            state     <= ST_IDLE;
            seen_word <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
      endcase
    end
  end

  // One-entry holding register; a release on the same edge frees the slot for the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending          <= 1'b0;
      hold             <= '0;
      out_wr_fifo_en   <= 1'b0;
      out_wr_fifo_data <= '0;
      out_overflow     <= 1'b0;
    end else begin
      out_wr_fifo_en <= rel;
      if (rel) out_wr_fifo_data <= hold;
      if (enq && (!pending || rel)) begin
        hold    <= enq_word;
        pending <= 1'b1;
      end else if (rel) begin
        pending <= 1'b0;
      end
      if (enq && pending && !rel) out_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_wpack.sv
// Scoreboard bench for rgb_wpack: expected FIFO words queued at stimulus time, popped on each write pulse.
module tb_rgb_wpack;

  localparam bit SRST_ALWAYS = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_strobe, in_stream_reset, in_sbit_value, in_wr_fifo_full;
  logic        out_wr_fifo_en;
  logic [31:0] out_wr_fifo_data;
  logic        out_overflow, out_frag_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwr = 0;
  int last_wr_cyc = 0;
  int last_rise = 0;
  logic prev_en = 1'b0;

  logic [31:0] exp_q[$];
  int m_idx = 0;
  bit m_seen = 0;

  rgb_wpack #(.SRST_ALWAYS(SRST_ALWAYS)) dut (
    .clk(clk), .rst(rst),
    .in_strobe(in_strobe), .in_stream_reset(in_stream_reset), .in_sbit_value(in_sbit_value),
    .in_wr_fifo_full(in_wr_fifo_full),
    .out_wr_fifo_en(out_wr_fifo_en), .out_wr_fifo_data(out_wr_fifo_data),
    .out_overflow(out_overflow), .out_frag_err(out_frag_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every pulse must match the oldest expected word and last one clock.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_wr_fifo_en === 1'b1) begin
        logic [31:0] e;
        nwr++;
        last_wr_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %h expected none", out_wr_fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (out_wr_fifo_data !== e) begin
            errors++;
            $display("FAIL write_data got %h expected %h", out_wr_fifo_data, e);
          end
        end
        checks++;
        if (prev_en !== 1'b0) begin
          errors++;
          $display("FAIL en_width got en high two clocks expected one");
        end
      end
      prev_en = out_wr_fifo_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  function automatic void model_word(input logic [23:0] w, input bit written);
    logic [5:0] f;
    f = '0;
`ifdef RGB_WPACK_PIX_IDX_EN
    f = m_idx[5:0];
`endif
    if (written) exp_q.push_back({1'b1, 1'b0, f, w});
    m_idx++;
    m_seen = 1;
  endfunction

  function automatic void model_srst();
    if (m_seen || SRST_ALWAYS) exp_q.push_back(32'hC000_0000);
    m_seen = 0;
    m_idx  = 0;
  endfunction

  task automatic send_ev(input logic srst, input logic b, input int hold_clks);
    @(posedge clk); #1;
    in_stream_reset = srst;
    in_sbit_value   = b;
    in_strobe       = 1'b1;
    last_rise       = cyc;
    repeat (hold_clks) @(posedge clk);
    #1 in_strobe = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input int hold_clks);
    for (int i = n - 1; i >= 0; i--) send_ev(1'b0, w[i], hold_clks);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_strobe = 0; in_stream_reset = 0; in_sbit_value = 0; in_wr_fifo_full = 0;
    idle(3);
    checks++; if (out_wr_fifo_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b expected 0", out_wr_fifo_en); end
    checks++; if (out_wr_fifo_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h expected 0", out_wr_fifo_data); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b expected 0", out_overflow); end
    checks++; if (out_frag_err !== 1'b0) begin errors++; $display("FAIL rst_frag got %b expected 0", out_frag_err); end
    @(negedge clk) rst = 1'b1;
    idle(2);
  endtask

  task automatic test_word;
    int n0;
    n0 = nwr;
    model_word(24'hA5C3F0, 1);
    send_bits(24'hA5C3F0, 24, 2);
    idle(3);
    checks++; if (nwr !== n0 + 1) begin errors++; $display("FAIL word_count got %0d expected %0d", nwr - n0, 1); end
    checks++; if (last_wr_cyc - last_rise !== 2) begin errors++; $display("FAIL word_latency got %0d expected 2", last_wr_cyc - last_rise); end
    checks++; if (out_wr_fifo_data !== 32'h80A5C3F0) begin errors++; $display("FAIL word_hold got %h expected 80a5c3f0", out_wr_fifo_data); end
  endtask

  task automatic test_marker;
    int n0;
    n0 = nwr;
    model_word(24'h123456, 1);
    send_bits(24'h123456, 24, 2);
    model_srst();
    send_ev(1'b1, 1'b0, 2);
    idle(3);
    checks++; if (nwr !== n0 + 2) begin errors++; $display("FAIL marker_count got %0d expected 2", nwr - n0); end
    n0 = nwr;
    model_srst();
    send_ev(1'b1, 1'b0, 3);
    idle(3);
    checks++; if (nwr !== n0 + (SRST_ALWAYS ? 1 : 0)) begin errors++; $display("FAIL second_srst got %0d writes", nwr - n0); end
  endtask

  task automatic test_frag;
    checks++; if (out_frag_err !== 1'b0) begin errors++; $display("FAIL frag_pre got %b expected 0", out_frag_err); end
    send_bits(24'h0003FF, 10, 2);
    model_srst();
    send_ev(1'b1, 1'b0, 2);
    idle(2);
    checks++; if (out_frag_err !== 1'b1) begin errors++; $display("FAIL frag_set got %b expected 1", out_frag_err); end
    model_word(24'h0F0F0F, 1);
    send_bits(24'h0F0F0F, 24, 2);
    idle(3);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL frag_clean got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow;
    int n0;
    n0 = nwr;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b expected 0", out_overflow); end
    in_wr_fifo_full = 1'b1;
    model_word(24'hDEADBE, 1);
    send_bits(24'hDEADBE, 24, 2);
    model_word(24'h654321, 0);
    send_bits(24'h654321, 24, 2);
    idle(5);
    checks++; if (nwr !== n0) begin errors++; $display("FAIL ovf_stall got %0d writes expected 0", nwr - n0); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", out_overflow); end
    in_wr_fifo_full = 1'b0;
    idle(6);
    checks++; if (nwr !== n0 + 1) begin errors++; $display("FAIL ovf_release got %0d writes expected 1", nwr - n0); end
  endtask

  task automatic test_hold_reset;
    int n0;
    model_word(24'h5A5A5A, 1);
    send_bits(24'h5A5A5A, 24, 5);
    idle(3);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL long_strobe got %0d pending expected 0", exp_q.size()); end
    in_wr_fifo_full = 1'b1;
    model_word(24'h777777, 0);
    send_bits(24'h777777, 24, 2);
    send_bits(24'h000ABC, 12, 2);
    n0 = nwr;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    checks++; if (out_wr_fifo_en !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %b expected 0", out_wr_fifo_en); end
    checks++; if (out_wr_fifo_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h expected 0", out_wr_fifo_data); end
    checks++; if (out_overflow !== 1'b0 || out_frag_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_sticky got ovf=%b frag=%b expected 0 0", out_overflow, out_frag_err); end
    in_wr_fifo_full = 1'b0;
    idle(2);
    @(negedge clk) rst = 1'b1;
    m_idx = 0; m_seen = 0;
    idle(4);
    checks++; if (nwr !== n0) begin errors++; $display("FAIL rst_lost got %0d writes expected 0", nwr - n0); end
    model_word(24'hC0FFEE, 1);
    send_bits(24'hC0FFEE, 24, 5);
    idle(3);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL post_rst got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] px[4] = '{24'h010203, 24'hFFFFFF, 24'h000000, 24'h80007F};
    int n0;
    n0 = nwr;
    for (int i = 0; i < 3; i++) begin
      model_word(px[i], 1);
      send_bits(px[i], 24, 1 + (i % 2));
    end
    model_srst();
    send_ev(1'b1, 1'b0, 2);
    model_word(px[3], 1);
    send_bits(px[3], 24, 2);
    idle(4);
    checks++; if (nwr !== n0 + 5) begin errors++; $display("FAIL b2b_count got %0d expected 5", nwr - n0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_marker();
    test_frag();
    test_overflow();
    test_hold_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
